// File: rtl/load_store_unit_pkg.sv
// Shared CPU package: data-memory sizing and load/store unit state encoding.
package load_store_unit_pkg;

  localparam int LSU_ADDR_W = 10;
  localparam int LSU_DATA_W = 20;
  localparam int MEM_WORDS  = 1 << LSU_ADDR_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: one request per two cycles against a single-port data memory
// whose write strobe is the active-low MemLoud line.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              Req,
  input  logic              IsStore,
  input  logic [ADDR_W-1:0] Base,
  input  logic [ADDR_W-1:0] Offset,
  input  logic [DATA_W-1:0] StoreData,
  output logic              Ready,
  output logic              Done,
  output logic [DATA_W-1:0] LoadData,
  output logic [ADDR_W-1:0] MemAddress,
  output logic              MemLoud,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;
  logic              mem_loud_q, mem_loud_d;
  logic              accept;

  assign Ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign accept = Req && Ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    load_data_d = load_data_q;
    // The write strobe is registered so it can never glitch low.
    mem_loud_d  = 1'b1;
    case (state_q)
      ST_LOAD: begin
        load_data_d = MemDataOut;
        state_d     = ST_DONE;
      end
      ST_STORE: state_d = ST_DONE;
      default: begin
        if (accept) begin
          addr_d     = Base + Offset;
          data_d     = StoreData;
          state_d    = IsStore ? ST_STORE : ST_LOAD;
          mem_loud_d = !IsStore;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      load_data_q <= '0;
      mem_loud_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      load_data_q <= load_data_d;
      mem_loud_q  <= mem_loud_d;
    end
  end

  assign Done       = (state_q == ST_DONE);
  assign LoadData   = load_data_q;
  assign MemAddress = addr_q;
  assign MemDataIn  = data_q;
  assign MemLoud    = mem_loud_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the data-memory address width (1024 words).
REQ-002 SHALL have parameter DATA_W, default 20, meaning the data-memory word width.
REQ-003 SHALL have port Clock, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port Clear, input, 1, reset: asynchronous, active-high.
REQ-005 SHALL have port Req, input, 1, CPU memory request valid.
REQ-006 SHALL have port IsStore, input, 1, 1 = store, 0 = load; sampled with Req.
REQ-007 SHALL have port Base, input, ADDR_W, base address operand.
REQ-008 SHALL have port Offset, input, ADDR_W, offset operand (two's complement).
REQ-009 SHALL have port StoreData, input, DATA_W, store write data.
REQ-010 SHALL have port Ready, output, 1, unit can accept a request this cycle.
REQ-011 SHALL have port Done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port LoadData, output, DATA_W, load result; valid when Done is high after a load.
REQ-013 SHALL have port MemAddress, output, ADDR_W, data-memory address.
REQ-014 SHALL have port MemLoud, output, 1, data-memory read enable; 0 = memory writes this edge.
REQ-015 SHALL have port MemDataIn, output, DATA_W, data-memory write data.
REQ-016 SHALL have port MemDataOut, input, DATA_W, data-memory combinational read data.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, STORE, DONE.
REQ-018 SHALL assert Ready in IDLE and DONE only.
REQ-019 SHALL accept a request when Req and Ready are both high: register the address, IsStore and StoreData, then go to LOAD or STORE.
REQ-020 SHALL compute the effective address as (Base + Offset) mod 2^ADDR_W; carry is discarded and wrap-around is silent.
REQ-021 SHALL drive MemLoud from a flop and hold it high in every state except STORE, because memory writes whenever MemLoud is low.
REQ-022 SHALL drive MemLoud low for exactly one cycle in STORE, with MemAddress and MemDataIn stable from registers during that cycle.
REQ-023 SHALL, in LOAD, hold MemLoud high and MemAddress at the registered address, and capture MemDataOut into LoadData at the end of the cycle.
REQ-024 SHALL move from LOAD or STORE to DONE unconditionally and raise Done for exactly one cycle.
REQ-025 SHALL give a latency of 2 cycles from the accept edge to Done high; throughput is one request per 2 cycles (accept in DONE goes straight to LOAD/STORE).
REQ-026 SHALL go from DONE to IDLE when no request is accepted in DONE.
REQ-027 SHALL hold LoadData until the next load completes; a store leaves LoadData unchanged.
REQ-028 SHALL ignore Req while Ready is low; no request is queued or dropped silently.
REQ-029 SHALL hold MemDataIn at its last registered value when idle; it is a don't-care while MemLoud is high.

Reset
REQ-030 SHALL, on Clear high, immediately force state = IDLE, MemLoud = 1, Done = 0, Ready = 1, MemAddress = 0, MemDataIn = 0, LoadData = 0.
REQ-031 SHALL abort an in-flight store when Clear asserts during STORE: MemLoud returns high asynchronously and no Done is issued.
REQ-032 SHALL accept no request on the edge where Clear is deasserting.

Structure
REQ-033 SHALL define the state encoding, ADDR_W and DATA_W defaults in the shared CPU package, alongside the memory sizing constants.
REQ-034 SHALL be a single module with no sub-modules; the address adder is inline.

Verification
REQ-035 SHALL cover a store then a load: store 0x12345 at Base 0x010, Offset 0x005 -> MemLoud low 1 cycle, addr 0x015; load from the same address -> LoadData 0x12345 with Done 2 cycles after accept.
REQ-036 SHALL cover wrap-around: Base 0x3FF, Offset 0x002 -> MemAddress 0x001; Base 0x005, Offset 0x3FE (-2) -> MemAddress 0x003.
REQ-037 SHALL cover back-to-back: Req held high with 3 loads -> accepts in IDLE, DONE, DONE; Done every 2nd cycle; MemLoud never low.
REQ-038 SHALL cover reset mid-store: Clear asserted in STORE -> MemLoud high immediately, target word unchanged, Done never pulses.
REQ-039 SHALL cover backpressure: Req in LOAD/STORE state -> Ready 0, request not accepted, no extra memory access.
REQ-040 SHALL cover an idle check: 100 idle cycles after reset -> MemLoud constantly 1 and memory contents unchanged.
